// File: rtl/regfile_scan_ctrl.sv
// Register-file scan controller: reads every register in address order, folds the data into
// max/min/sum/XOR accumulators, then writes the selected reduction back to a chosen register.
module regfile_scan_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Start,
  input  logic [1:0]               Mode,
  input  logic [ADDR_W-1:0]        Dest_Addr,
  output logic [ADDR_W-1:0]        R_Addr,
  output logic                     R_en,
  input  logic [DATA_W-1:0]        R_Data,
  output logic [ADDR_W-1:0]        W_Addr,
  output logic                     W_en,
  output logic [DATA_W-1:0]        W_Data,
  output logic                     Busy,
  output logic                     Done,
  output logic [DATA_W-1:0]        Result,
  output logic [DATA_W+ADDR_W-1:0] Sum
);

  localparam int                SUM_W    = DATA_W + ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   idx_r;
  logic [1:0]          mode_r;
  logic [ADDR_W-1:0]   dest_r;
  logic [DATA_W-1:0]   acc_max_r;
  logic [DATA_W-1:0]   acc_min_r;
  logic [SUM_W-1:0]    acc_sum_r;
  logic [DATA_W-1:0]   acc_xor_r;
  logic                r_en_r;
  logic [ADDR_W-1:0]   w_addr_r;
  logic                w_en_r;
  logic [DATA_W-1:0]   w_data_r;
  logic                busy_r;
  logic                done_r;
  logic [DATA_W-1:0]   result_r;
  logic [SUM_W-1:0]    sum_r;

  logic [DATA_W-1:0]   max_nxt_s;
  logic [DATA_W-1:0]   min_nxt_s;
  logic [SUM_W-1:0]    sum_nxt_s;
  logic [DATA_W-1:0]   xor_nxt_s;

  function automatic logic [DATA_W-1:0] select_reduction(
    input logic [1:0]        mode,
    input logic [DATA_W-1:0] mx,
    input logic [DATA_W-1:0] mn,
    input logic [SUM_W-1:0]  sm,
    input logic [DATA_W-1:0] xr
  );
    logic [DATA_W-1:0] sel;
    case (mode)
      2'd0:    sel = mx;
      2'd1:    sel = mn;
      2'd2:    sel = sm[DATA_W-1:0];
      2'd3:    sel = xr;
      default: sel = {DATA_W{1'b0}};
    endcase
    return sel;
  endfunction

  // Accumulator values after folding in the current read word.
  always_comb begin
    max_nxt_s = acc_max_r;
    min_nxt_s = acc_min_r;
    if (R_Data > acc_max_r) begin
      max_nxt_s = R_Data;
    end else begin
      max_nxt_s = acc_max_r;
    end
    if (R_Data < acc_min_r) begin
      min_nxt_s = R_Data;
    end else begin
      min_nxt_s = acc_min_r;
    end
    sum_nxt_s = acc_sum_r + SUM_W'(R_Data);
    xor_nxt_s = acc_xor_r ^ R_Data;
  end

  // Scan FSM with all outputs registered.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r   <= ST_IDLE;
      idx_r     <= {ADDR_W{1'b0}};
      mode_r    <= 2'd0;
      dest_r    <= {ADDR_W{1'b0}};
      acc_max_r <= {DATA_W{1'b0}};
      acc_min_r <= {DATA_W{1'b0}};
      acc_sum_r <= {SUM_W{1'b0}};
      acc_xor_r <= {DATA_W{1'b0}};
      r_en_r    <= 1'b0;
      w_addr_r  <= {ADDR_W{1'b0}};
      w_en_r    <= 1'b0;
      w_data_r  <= {DATA_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= {DATA_W{1'b0}};
      sum_r     <= {SUM_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (Start) begin
            mode_r    <= Mode;
            dest_r    <= Dest_Addr;
            idx_r     <= {ADDR_W{1'b0}};
            acc_max_r <= {DATA_W{1'b0}};
            acc_min_r <= {DATA_W{1'b1}};
            acc_sum_r <= {SUM_W{1'b0}};
            acc_xor_r <= {DATA_W{1'b0}};
            r_en_r    <= 1'b1;
            busy_r    <= 1'b1;
            state_r   <= ST_READ;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          acc_max_r <= max_nxt_s;
          acc_min_r <= min_nxt_s;
          acc_sum_r <= sum_nxt_s;
          acc_xor_r <= xor_nxt_s;
          if (idx_r == LAST_IDX) begin
            // Write data is taken from the post-fold values so WRITE needs no extra cycle.
            idx_r    <= {ADDR_W{1'b0}};
            r_en_r   <= 1'b0;
            w_en_r   <= 1'b1;
            w_addr_r <= dest_r;
            w_data_r <= select_reduction(mode_r, max_nxt_s, min_nxt_s, sum_nxt_s, xor_nxt_s);
            state_r  <= ST_WRITE;
          end else begin
            idx_r <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        ST_WRITE: begin
          w_en_r   <= 1'b0;
          w_addr_r <= {ADDR_W{1'b0}};
          w_data_r <= {DATA_W{1'b0}};
          result_r <= w_data_r;
          sum_r    <= acc_sum_r;
          done_r   <= 1'b1;
          state_r  <= ST_DONE;
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          r_en_r  <= 1'b0;
          w_en_r  <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // A reset arriving during WRITE must block the register-file write at that same edge.
  assign W_en   = w_en_r & ~Rst;
  assign R_Addr = idx_r;
  assign R_en   = r_en_r;
  assign W_Addr = w_addr_r;
  assign W_Data = w_data_r;
  assign Busy   = busy_r;
  assign Done   = done_r;
  assign Result = result_r;
  assign Sum    = sum_r;

endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// Scoreboard bench for regfile_scan_ctrl: a behavioural 16x8 register file feeds the DUT and
// a monitor checks write-backs and completions against expectations queued by the stimulus.
module tb_regfile_scan_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [1:0]  Mode;
  logic [3:0]  Dest_Addr;
  logic [3:0]  R_Addr;
  logic        R_en;
  logic [7:0]  R_Data;
  logic [3:0]  W_Addr;
  logic        W_en;
  logic [7:0]  W_Data;
  logic        Busy;
  logic        Done;
  logic [7:0]  Result;
  logic [11:0] Sum;

  regfile_scan_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Mode(Mode), .Dest_Addr(Dest_Addr),
    .R_Addr(R_Addr), .R_en(R_en), .R_Data(R_Data),
    .W_Addr(W_Addr), .W_en(W_en), .W_Data(W_Data),
    .Busy(Busy), .Done(Done), .Result(Result), .Sum(Sum)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]  dest;
    logic [7:0]  result;
    logic [11:0] sum;
    int          issue_cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem [16];
  logic [7:0] pre_mem [16];
  logic       pre_go = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         rd_idx = 0;
  int         wen_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // register file model
  assign R_Data = R_en ? mem[R_Addr] : 8'h00;
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (pre_go) begin
      for (int i = 0; i < 16; i++) mem[i] <= pre_mem[i];
    end else if (W_en) begin
      mem[W_Addr] <= W_Data;
    end
  end

  // monitor / scoreboard
  always @(negedge Clk) begin
    exp_t e;
    if (!Busy) begin
      rd_idx  = 0;
      wen_cnt = 0;
    end
    if (R_en) begin
      chk("r_addr_seq", {28'd0, R_Addr}, rd_idx);
      rd_idx++;
    end
    if (W_en) begin
      wen_cnt++;
      if (exp_q.size() == 0) begin
        chk("spurious_wen", {31'd0, W_en}, 32'd0);
      end else begin
        chk("w_addr", {28'd0, W_Addr}, {28'd0, exp_q[0].dest});
        chk("w_data", {24'd0, W_Data}, {24'd0, exp_q[0].result});
      end
    end
    if (Done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", {31'd0, Done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result", {24'd0, Result}, {24'd0, e.result});
        chk("sum", {20'd0, Sum}, {20'd0, e.sum});
        chk("done_latency", cyc - e.issue_cyc, 32'd18);
        chk("read_count", rd_idx, 32'd16);
        chk("wen_count", wen_cnt, 32'd1);
        chk("busy_in_done", {31'd0, Busy}, 32'd1);
      end
    end
  end

  task automatic preload(input logic [7:0] v [16]);
    @(negedge Clk);
    for (int i = 0; i < 16; i++) pre_mem[i] = v[i];
    pre_go = 1'b1;
    @(negedge Clk);
    pre_go = 1'b0;
  endtask

  task automatic issue(input logic [1:0] m, input logic [3:0] d,
                       input logic [7:0] res, input logic [11:0] sm);
    exp_t e;
    @(negedge Clk);
    Mode      = m;
    Dest_Addr = d;
    Start     = 1'b1;
    e.dest = d; e.result = res; e.sum = sm; e.issue_cyc = cyc;
    exp_q.push_back(e);
    @(negedge Clk);
    Start     = 1'b0;
    Mode      = ~m;
    Dest_Addr = ~d;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || Busy) && n < 40) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 40) begin
      chk("scan_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  logic [7:0] tp    [16];
  logic [7:0] ones  [16];
  logic [7:0] zeros [16];

  initial begin
    tp = '{8'd254, 8'd169, 8'd156, 8'd250, 8'd145, 8'd247, 8'd128, 8'd232,
           8'd249, 8'd105, 8'd189, 8'd172, 8'd65, 8'd180, 8'd218, 8'd39};
    for (int i = 0; i < 16; i++) begin
      ones[i]  = 8'hFF;
      zeros[i] = 8'h00;
    end
    Rst = 1'b1; Start = 1'b0; Mode = 2'd0; Dest_Addr = 4'd0;
    repeat (3) @(negedge Clk);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_r_en", {31'd0, R_en}, 32'd0);
    chk("rst_w_en", {31'd0, W_en}, 32'd0);
    chk("rst_r_addr", {28'd0, R_Addr}, 32'd0);
    chk("rst_w_data", {24'd0, W_Data}, 32'd0);
    chk("rst_result", {24'd0, Result}, 32'd0);
    chk("rst_sum", {20'd0, Sum}, 32'd0);
    Rst = 1'b0;

    preload(tp); issue(2'd0, 4'd0,  8'd254, 12'd2798); wait_idle();
    preload(tp); issue(2'd1, 4'd15, 8'd39,  12'd2798); wait_idle();
    chk("reg15_written", {24'd0, mem[15]}, 32'd39);
    preload(tp); issue(2'd2, 4'd7,  8'hEE,  12'hAEE);  wait_idle();
    chk("reg7_written", {24'd0, mem[7]}, 32'd238);
    preload(tp); issue(2'd3, 4'd9,  8'hB6,  12'hAEE);  wait_idle();
    preload(ones);  issue(2'd2, 4'd1, 8'hF0, 12'd4080); wait_idle();
    preload(zeros); issue(2'd1, 4'd2, 8'h00, 12'd0);    wait_idle();

    // Start with a different Mode during READ must be ignored
    preload(tp); issue(2'd0, 4'd3, 8'd254, 12'd2798);
    repeat (4) @(negedge Clk);
    Mode = 2'd1; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_idle();
    repeat (3) @(negedge Clk);
    chk("ignored_start_idle", {31'd0, Busy}, 32'd0);

    // reset in the middle of READ
    preload(tp); issue(2'd0, 4'd5, 8'd254, 12'd2798);
    repeat (8) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    exp_q.delete();
    chk("midrst_busy", {31'd0, Busy}, 32'd0);
    chk("midrst_r_en", {31'd0, R_en}, 32'd0);
    chk("midrst_w_en", {31'd0, W_en}, 32'd0);
    chk("midrst_result", {24'd0, Result}, 32'd0);
    chk("midrst_sum", {20'd0, Sum}, 32'd0);
    Rst = 1'b0;
    repeat (20) @(negedge Clk);
    chk("midrst_reg5", {24'd0, mem[5]}, 32'd247);

    // reset coincident with WRITE must suppress the write
    preload(tp); issue(2'd0, 4'd2, 8'd254, 12'd2798);
    begin
      int n;
      n = 0;
      while (!W_en && n < 30) begin
        @(negedge Clk);
        n++;
      end
      chk("wen_seen", {31'd0, W_en}, 32'd1);
    end
    Rst = 1'b1;
    @(negedge Clk);
    exp_q.delete();
    chk("wrst_reg2_kept", {24'd0, mem[2]}, 32'd156);
    chk("wrst_done", {31'd0, Done}, 32'd0);
    chk("wrst_result", {24'd0, Result}, 32'd0);
    Rst = 1'b0;

    // normal scan after reset
    preload(tp); issue(2'd3, 4'd4, 8'hB6, 12'hAEE); wait_idle();
    chk("post_rst_reg4", {24'd0, mem[4]}, 32'd182);

    repeat (3) @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
